pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/synth_pkg.sv | 19 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/pwm_decoder.sv | 143 ++++++++++++++
 tb/tb_pwm_decoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared synth constants and types used by the synth blocks and test wrappers.
package synth_pkg;

    // Audio/carrier resolution shared by the synth PWM output and the decoder.
    localparam int SYNTH_PWM_W   = 8;
    // Number of GPIO pins on the wrapper pin map.
    localparam int SYNTH_GPIO_W  = 38;

    // Default resolution of the PWM loop-back decoder.
    localparam int PWM_DEC_W_DEFAULT = SYNTH_PWM_W;

    // Decoder FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } pwm_dec_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a registered rising-edge detector.
// level_o and rise_o refer to the same input sample, so they stay aligned.
module sync_edge_det (
    input  logic clk,
    input  logic n_rst,
    input  logic in_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the asynchronous input and register rise = sync2 & ~prev.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            rise_o <= 1'b0;
        end else begin
            sync1  <= in_i;
            sync2  <= sync1;
            prev   <= sync2;
            rise_o <= sync2 & ~prev;
        end
    end

    // prev holds the same sample that produced the registered rise_o.
    assign level_o = prev;

endmodule

// File: rtl/pwm_decoder.sv
// Measures high-time and period of a looped-back PWM stream.
// Reports each complete period with a one-cycle valid_o strobe, and flags a
// stuck input when no rising edge arrives within 2^(W+1)-1 cycles.
module pwm_decoder
    import synth_pkg::*;
#(
    parameter int W = PWM_DEC_W_DEFAULT
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic         pwm_i,
    output logic [W-1:0] duty_o,
    output logic [W:0]   period_o,
    output logic         valid_o,
    output logic         stuck_o
);

    localparam logic [W:0]   PER_MAX = '1;
    localparam logic [W-1:0] HI_MAX  = '1;

    pwm_dec_state_e state_q;
    pwm_dec_state_e state_d;

    logic         level;
    logic         rise;
    logic         level_q;
    logic         rise_q;
    logic [W:0]   per_cnt;
    logic [W-1:0] hi_cnt;

    logic         restart;
    logic         report;
    logic         go_stuck;
    logic         clr_stuck;

    sync_edge_det u_sync (
        .clk     (clk),
        .n_rst   (n_rst),
        .in_i    (pwm_i),
        .level_o (level),
        .rise_o  (rise)
    );

    // Extra alignment stage: gives the fixed 4-cycle input-to-valid latency.
    // Runs regardless of en so no stale edge is seen when en returns.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            level_q <= level;
            rise_q  <= rise;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and datapath controls; a rise always wins over saturation.
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        report    = 1'b0;
        go_stuck  = 1'b0;
        clr_stuck = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rise_q) begin
                        state_d = MEASURE;
                        restart = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise_q) begin
                        report  = 1'b1;
                        restart = 1'b1;
                    end else if (per_cnt == PER_MAX) begin
                        state_d  = STUCK;
                        go_stuck = 1'b1;
                    end
                end
                STUCK: begin
                    if (rise_q) begin
                        state_d   = MEASURE;
                        restart   = 1'b1;
                        clr_stuck = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating period/high-time counters; the rise cycle counts as cycle 1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (!en) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (restart) begin
            per_cnt <= (W+1)'(1);
            hi_cnt  <= W'(level_q);
        end else if (state_q == MEASURE) begin
            if (per_cnt != PER_MAX)          per_cnt <= per_cnt + (W+1)'(1);
            if (level_q && hi_cnt != HI_MAX) hi_cnt  <= hi_cnt + W'(1);
        end else if (state_q == IDLE) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end
    end

    // Result registers and status; duty/period hold across en=0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            duty_o   <= '0;
            period_o <= '0;
            valid_o  <= 1'b0;
            stuck_o  <= 1'b0;
        end else begin
            valid_o <= report | go_stuck;
            if (report) begin
                duty_o   <= hi_cnt;
                period_o <= per_cnt;
            end else if (go_stuck) begin
                duty_o   <= level_q ? HI_MAX : '0;
                period_o <= '0;
            end
            if (!en)            stuck_o <= 1'b0;
            else if (go_stuck)  stuck_o <= 1'b1;
            else if (clr_stuck) stuck_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: directed scenarios plus random waves,
// compared every cycle against a queue-based reference model.
module tb_pwm_decoder;

    localparam int W     = 8;
    localparam int PMAX  = (1 << (W + 1)) - 1;
    localparam int HMAX  = (1 << W) - 1;
    localparam int LAT   = 4;
    localparam int M_IDLE = 0, M_MEAS = 1, M_STUCK = 2;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         en;
    logic         pwm_i;
    logic [W-1:0] duty_o;
    logic [W:0]   period_o;
    logic         valid_o;
    logic         stuck_o;

    pwm_decoder #(.W(W)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .en       (en),
        .pwm_i    (pwm_i),
        .duty_o   (duty_o),
        .period_o (period_o),
        .valid_o  (valid_o),
        .stuck_o  (stuck_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: input history (index k = sample k edges ago),
    // samples of the current period, and the expected outputs.
    int hist [0:LAT+1];
    int q [$];
    int m_mode, m_duty, m_period, m_valid, m_stuck;

    // Bench bookkeeping.
    int cyc = 0;
    int strobes, stuck_strobes, first_strobe;
    int rises [$];
    logic last_p = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= LAT + 1; i++) hist[i] = 0;
        q.delete();
        m_mode = M_IDLE; m_duty = 0; m_period = 0; m_valid = 0; m_stuck = 0;
    endtask

    // The decoder acts on the input sampled LAT edges ago.
    task automatic model_step();
        int lvl, rs;
        for (int i = LAT + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'(pwm_i);
        lvl = hist[LAT];
        rs  = (hist[LAT] == 1 && hist[LAT+1] == 0) ? 1 : 0;
        m_valid = 0;
        if (!en) begin
            m_mode = M_IDLE; m_stuck = 0; q.delete();
        end else if (m_mode == M_IDLE) begin
            if (rs == 1) begin m_mode = M_MEAS; q = {1}; end
        end else if (m_mode == M_MEAS) begin
            if (rs == 1) begin
                m_period = (q.size() > PMAX) ? PMAX : q.size();
                m_duty   = (q.sum() > HMAX) ? HMAX : q.sum();
                m_valid  = 1;
                q = {1};
            end else if (q.size() >= PMAX) begin
                m_mode = M_STUCK; m_stuck = 1; m_valid = 1;
                m_period = 0; m_duty = (lvl == 1) ? HMAX : 0;
            end else begin
                q.push_back(lvl);
            end
        end else begin
            if (rs == 1) begin m_mode = M_MEAS; m_stuck = 0; q = {1}; end
        end
    endtask

    task automatic tick(input logic p, input logic e);
        pwm_i = p;
        en    = e;
        @(posedge clk);
        if (n_rst) model_step();
        else       model_reset();
        #1;
        cyc++;
        if (p && !last_p) rises.push_back(cyc);
        last_p = p;
        chk("valid",  valid_o,  m_valid);
        chk("stuck",  stuck_o,  m_stuck);
        chk("duty",   duty_o,   m_duty);
        chk("period", period_o, m_period);
        if (valid_o) begin
            strobes++;
            if (stuck_o) stuck_strobes++;
            if (first_strobe < 0) first_strobe = cyc;
        end
    endtask

    task automatic wave(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++) tick(i < hi, 1'b1);
    endtask

    task automatic clear_stats();
        strobes = 0; stuck_strobes = 0; first_strobe = -1; rises.delete();
    endtask

    initial begin
        int per, hi, n, drop_at;
        logic drop;
        n_rst = 1'b0; en = 1'b0; pwm_i = 1'b0;
        model_reset();
        clear_stats();
        repeat (3) tick(1'b0, 1'b0);
        chk("rst_duty", duty_o, 0);
        chk("rst_period", period_o, 0);
        chk("rst_valid", valid_o, 0);
        n_rst = 1'b1;

        // 256/64 square wave, four periods: three strobes, latency 4.
        repeat (5) tick(1'b0, 1'b1);
        clear_stats();
        wave(256, 64, 4);
        chk("sq_strobes", strobes, 3);
        chk("sq_duty", duty_o, 64);
        chk("sq_period", period_o, 256);
        chk("sq_latency", (rises.size() > 1) ? first_strobe - rises[1] : -1, LAT);

        // Duty extremes.
        wave(256, 1, 3);
        chk("h1_duty", duty_o, 1);
        chk("h1_period", period_o, 256);
        wave(256, 255, 3);
        chk("h255_duty", duty_o, 255);
        chk("h255_period", period_o, 256);

        // Rise exactly at saturation takes the rise path.
        clear_stats();
        wave(511, 10, 3);
        chk("sat_stuckstrobes", stuck_strobes, 0);
        chk("sat_period", period_o, 511);

        // Stuck high.
        clear_stats();
        repeat (600) tick(1'b1, 1'b1);
        chk("hi_stuckstrobes", stuck_strobes, 1);
        chk("hi_stuck", stuck_o, 1);
        chk("hi_duty", duty_o, 255);
        chk("hi_period", period_o, 0);
        repeat (3) tick(1'b0, 1'b1);
        clear_stats();
        repeat (8) tick(1'b1, 1'b1);
        chk("hi_clear", stuck_o, 0);
        chk("hi_clear_strobes", strobes, 0);

        // Stuck low, then a normal 256/128 wave.
        repeat (600) tick(1'b0, 1'b1);
        chk("lo_stuck", stuck_o, 1);
        chk("lo_duty", duty_o, 0);
        clear_stats();
        wave(256, 128, 3);
        chk("lo_strobes", strobes, 2);
        chk("lo_duty2", duty_o, 128);
        chk("lo_latency", (rises.size() > 1) ? first_strobe - rises[1] : -1, LAT);

        // Enable dropped mid-period.
        repeat (50) tick(1'b1, 1'b1);
        clear_stats();
        repeat (5) tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);
        chk("en_strobes", strobes, 0);
        chk("en_duty_hold", duty_o, 128);
        chk("en_period_hold", period_o, 256);
        repeat (20) tick(1'b0, 1'b1);
        clear_stats();
        wave(256, 100, 3);
        chk("en_resume_strobes", strobes, 2);
        chk("en_resume_duty", duty_o, 100);

        // Asynchronous reset mid-period.
        repeat (30) tick(1'b1, 1'b1);
        repeat (30) tick(1'b0, 1'b1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_duty", duty_o, 0);
        chk("arst_period", period_o, 0);
        chk("arst_valid", valid_o, 0);
        chk("arst_stuck", stuck_o, 0);
        repeat (3) tick(1'b0, 1'b1);
        n_rst = 1'b1;
        repeat (5) tick(1'b0, 1'b1);
        clear_stats();
        wave(256, 50, 3);
        chk("arst_resume_strobes", strobes, 2);
        chk("arst_resume_duty", duty_o, 50);

        // Random waves with occasional enable drops; checked by the model.
        repeat (10) begin
            per  = int'($urandom_range(600, 20));
            hi   = int'($urandom_range(per - 1, 1));
            n    = int'($urandom_range(3, 2));
            drop = ($urandom_range(3, 0) == 0);
            drop_at = int'($urandom_range(per - 1, 0));
            for (int k = 0; k < n; k++)
                for (int i = 0; i < per; i++)
                    tick(i < hi, !(drop && k == 0 && i >= drop_at && i < drop_at + 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
